// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Multi-cycle multiply/divide unit for the E stage. Owns the
//                HI/LO registers, reports occupancy on Busy and commits the
//                pending result after MULT_CYCLES / DIV_CYCLES cycles.
//                Optional feature macro: MDU_MADD_EN (madd/maddu accumulate).
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HIWrite,
    input  logic        LOWrite,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW           = $clog2(c_MAX_CYCLES + 1);

    localparam logic [CW-1:0] c_MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] c_DIV_N  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] c_ONE    = CW'(1);

    // What the commit edge does with the pending value
    typedef enum logic [1:0] {
        MODE_SET  = 2'd0,   // {HI,LO} <= pending
        MODE_ADD  = 2'd1,   // {HI,LO} <= {HI,LO} + pending
        MODE_KEEP = 2'd2    // divide by zero: leave HI/LO alone
    } mode_e;

    logic [CW-1:0] cnt_q,  cnt_d;
    logic [63:0]   pend_q, pend_d;
    mode_e         mode_q, mode_d;
    logic [31:0]   hi_q,   hi_d;
    logic [31:0]   lo_q,   lo_d;

    logic        w_is_mul, w_is_div, w_is_madd, w_valid, w_signed;
    logic [63:0] w_a_ext, w_b_ext, w_prod;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag, w_quot, w_rem;

    assign Busy = (cnt_q != '0);
    assign HI   = hi_q;
    assign LO   = lo_q;

    // Op decode and launch-time datapath (product and quotient/remainder)
    always_comb begin
        w_is_mul  = (Op == 3'b000) || (Op == 3'b001);
        w_is_div  = (Op == 3'b010) || (Op == 3'b011);
`ifdef MDU_MADD_EN
        w_is_madd = (Op == 3'b100) || (Op == 3'b101);
`else
        w_is_madd = 1'b0;
`endif
        w_valid   = w_is_mul || w_is_div || w_is_madd;
        w_signed  = ~Op[0];

        // Sign/zero extension to 64 bits lets one multiplier serve both forms
        w_a_ext = w_signed ? {{32{A[31]}}, A} : {32'd0, A};
        w_b_ext = w_signed ? {{32{B[31]}}, B} : {32'd0, B};
        w_prod  = w_a_ext * w_b_ext;

        // Divide on magnitudes so the signed overflow case needs no special path
        w_a_neg  = w_signed & A[31];
        w_b_neg  = w_signed & B[31];
        w_a_mag  = w_a_neg ? (~A + 32'd1) : A;
        w_b_mag  = w_b_neg ? (~B + 32'd1) : B;
        w_b_safe = (B == 32'd0) ? 32'd1 : w_b_mag;
        w_q_mag  = w_a_mag / w_b_safe;
        w_r_mag  = w_a_mag % w_b_safe;
        w_quot   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
        w_rem    = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
    end

    // Next state: countdown and commit while busy, moves and launch while idle
    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        mode_d = mode_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (Busy) begin
            cnt_d = cnt_q - c_ONE;
            if (cnt_q == c_ONE) begin
                case (mode_q)
                    MODE_SET: {hi_d, lo_d} = pend_q;
                    MODE_ADD: {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
                    default:  ;
                endcase
            end
        end else begin
            if (HIWrite) hi_d = A;
            if (LOWrite) lo_d = A;
            if (Start && w_valid) begin
                if (w_is_div) begin
                    cnt_d  = c_DIV_N;
                    pend_d = {w_rem, w_quot};
                    mode_d = (B == 32'd0) ? MODE_KEEP : MODE_SET;
                end else begin
                    cnt_d  = c_MULT_N;
                    pend_d = w_prod;
                    mode_d = w_is_madd ? MODE_ADD : MODE_SET;
                end
            end
        end
    end

    // State registers; reset aborts any in-flight operation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            pend_q <= 64'd0;
            mode_q <= MODE_SET;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            mode_q <= mode_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit: directed vector table,
//                hand sequences for reset/collision cases, and randomized ops
//                against a plain-arithmetic reference model.
//                Honours MDU_MADD_EN when deciding madd/maddu expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A, B;
    logic        HIWrite, LOWrite;
    logic        Busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a, b, hi_pre, lo_pre, exp_hi, exp_lo;
        int          n;
    } vec_t;

    vec_t vecs[11];

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
        .HIWrite(HIWrite), .LOWrite(LOWrite), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk); HIWrite = 1'b1; A = h;
        @(negedge clk); HIWrite = 1'b0; LOWrite = 1'b1; A = l;
        @(negedge clk); LOWrite = 1'b0;
    endtask

    // Reference model: expected HI/LO and busy length from plain arithmetic
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l,
                         output logic [31:0] eh, output logic [31:0] el, output int n);
        logic [63:0] p;
        longint      sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = h; el = l; n = 0;
        case (op)
            3'd0: begin p = sa * sb; {eh, el} = p; n = MC; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; {eh, el} = p; n = MC; end
            3'd2: begin
                n = DC;
                if (b != 0) begin el = 32'(sa / sb); eh = 32'(sa % sb); end
            end
            3'd3: begin
                n = DC;
                if (b != 0) begin el = a / b; eh = a % b; end
            end
`ifdef MDU_MADD_EN
            3'd4: begin p = sa * sb; {eh, el} = {h, l} + p; n = MC; end
            3'd5: begin p = {32'd0, a} * {32'd0, b}; {eh, el} = {h, l} + p; n = MC; end
`endif
            default: ;
        endcase
    endtask

    task automatic run_case(input string nm, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                            input logic [31:0] eh, input logic [31:0] el, input int n);
        int cnt;
        preload(h, l);
        check({nm, " preload HI"}, HI, h);
        check({nm, " preload LO"}, LO, l);
        @(negedge clk); Start = 1'b1; Op = op; A = a; B = b;
        @(negedge clk); Start = 1'b0;
        if (Busy) begin
            check({nm, " HI held during busy"}, HI, h);
            check({nm, " LO held during busy"}, LO, l);
        end
        cnt = 0;
        while (Busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check({nm, " busy cycles"}, 32'(cnt), 32'(n));
        check({nm, " HI"}, HI, eh);
        check({nm, " LO"}, LO, el);
    endtask

    initial begin
        int          cnt;
        logic [2:0]  rop;
        logic [31:0] ra, rb, rh, rl, eh, el;
        int          rn;

        reset_n = 1'b0; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
        HIWrite = 1'b0; LOWrite = 1'b0;

        // Directed vectors
        vecs[0] = '{"mult",       3'd0, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        vecs[1] = '{"multu",      3'd1, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 32'h00000002, 32'hFFFFFFFA, MC};
        vecs[2] = '{"div",        3'd2, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3] = '{"divu",       3'd3, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'h00000001, 32'h7FFFFFFC, DC};
        vecs[4] = '{"div by 0",   3'd2, 32'd5, 32'd0, 32'h11, 32'h22, 32'h11, 32'h22, DC};
        vecs[5] = '{"divu by 0",  3'd3, 32'd5, 32'd0, 32'h33, 32'h44, 32'h33, 32'h44, DC};
        vecs[6] = '{"div ovf",    3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h9, 32'h9, 32'h0, 32'h80000000, DC};
        vecs[7] = '{"rsvd 110",   3'd6, 32'd7, 32'd7, 32'h55, 32'h66, 32'h55, 32'h66, 0};
        vecs[8] = '{"rsvd 111",   3'd7, 32'd7, 32'd7, 32'h77, 32'h88, 32'h77, 32'h88, 0};
`ifdef MDU_MADD_EN
        vecs[9]  = '{"maddu", 3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, MC};
        vecs[10] = '{"madd",  3'd4, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd5, 32'd0, 32'd4, MC};
`else
        vecs[9]  = '{"maddu", 3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 0};
        vecs[10] = '{"madd",  3'd4, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd5, 32'd0, 32'd5, 0};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("reset Busy", 32'(Busy), 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_case(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi_pre,
                     vecs[i].lo_pre, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].n);

        // Start and mthi while busy are ignored; the mult still commits on time
        preload(32'd0, 32'd0);
        @(negedge clk); Start = 1'b1; Op = 3'd0; A = 32'd7; B = 32'd6;
        @(negedge clk); Start = 1'b0;
        cnt = 0;
        while (Busy && cnt < 50) begin
            cnt++;
            if (cnt == 2) begin
                Start = 1'b1; Op = 3'd2; A = 32'hDEAD; B = 32'd1; HIWrite = 1'b1;
            end else begin
                Start = 1'b0; HIWrite = 1'b0;
            end
            @(negedge clk);
        end
        Start = 1'b0; HIWrite = 1'b0;
        check("collision busy cycles", 32'(cnt), 32'(MC));
        check("collision HI", HI, 32'd0);
        check("collision LO", LO, 32'd42);
        repeat (2) @(negedge clk);
        check("collision no relaunch", 32'(Busy), 32'd0);

        // mthi coinciding with launch: move lands first, commit overwrites
        @(negedge clk); Start = 1'b1; HIWrite = 1'b1; Op = 3'd0; A = 32'hDEAD; B = 32'd2;
        @(negedge clk); Start = 1'b0; HIWrite = 1'b0;
        check("move+start HI moved", HI, 32'hDEAD);
        check("move+start Busy", 32'(Busy), 32'd1);
        cnt = 0;
        while (Busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check("move+start busy cycles", 32'(cnt), 32'(MC));
        check("move+start HI", HI, 32'd0);
        check("move+start LO", LO, 32'h0001BD5A);

        // Reset mid-operation aborts with no commit
        preload(32'h1234, 32'h5678);
        @(negedge clk); Start = 1'b1; Op = 3'd3; A = 32'd100; B = 32'd3;
        @(negedge clk); Start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-abort Busy", 32'(Busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort Busy", 32'(Busy), 32'd0);
        check("abort HI", HI, 32'd0);
        check("abort LO", LO, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (DC + 2) @(negedge clk);
        check("abort no commit HI", HI, 32'd0);
        check("abort no commit LO", LO, 32'd0);
        check("abort stays idle", 32'(Busy), 32'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            rh  = $urandom;
            rl  = $urandom;
            model(rop, ra, rb, rh, rl, eh, el, rn);
            run_case($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, rh, rl, eh, el, rn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
